// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified instruction/data memory: access sizes,
// FSM states and the byte-lane count of one memory word.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_B   = 2'b00,
    MEM_SZ_H   = 2'b01,
    MEM_SZ_W   = 2'b10,
    MEM_SZ_RSV = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_state_e;

  localparam int LANES = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: sign/zero-extends the load word and produces
// per-lane store enables and store bytes for a byte/half/word access.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_word,
  output logic [3:0]  lane_en,
  output logic [31:0] store_word
);

  always_comb begin
    load_word = raw_word;
    lane_en   = 4'b1111;
    case (mem_size_e'(size))
      MEM_SZ_B: begin
        load_word = {{24{~is_unsigned & raw_word[7]}}, raw_word[7:0]};
        lane_en   = 4'b0001;
      end
      MEM_SZ_H: begin
        load_word = {{16{~is_unsigned & raw_word[15]}}, raw_word[15:0]};
        lane_en   = 4'b0011;
      end
      MEM_SZ_W: begin
        load_word = raw_word;
        lane_en   = 4'b1111;
      end
      default: begin
        load_word = '0;
        lane_en   = 4'b0000;
      end
    endcase
  end

  // Lane i always carries store byte i; address wrap is applied by the caller.
  assign store_word = wdata;

endmodule

// File: rtl/riscv_unified_mem.sv
// Byte-addressed unified memory with req/rsp handshake and fixed access latency.
// Define MEM_MISALIGN_FAULT_EN to fault misaligned half/word accesses instead of wrapping byte-wise.
module riscv_unified_mem
  import riscv_mem_pkg::*;
#(
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH_BYTES = 256,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             we_reg;
  logic             unsigned_reg;
  logic [IDX_W-1:0] addr_reg;
  mem_size_e        size_reg;
  logic [31:0]      wdata_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic [31:0]      rsp_rdata_reg;

  logic [7:0]       mem_reg [DEPTH_BYTES];
  logic [IDX_W-1:0] lane_idx [LANES];
  logic [31:0]      raw_word;
  logic [31:0]      load_word;
  logic [31:0]      store_word;
  logic [3:0]       lane_en;
  logic             access_err;
  logic             commit;

  generate
    if (ADDR_W > IDX_W) begin : g_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W];
    end
    // Multi-byte accesses wrap naturally because the index is IDX_W bits wide.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_idx[gi]          = addr_reg + IDX_W'(gi);
      assign raw_word[8*gi +: 8]   = mem_reg[lane_idx[gi]];
    end
  endgenerate

  mem_lane_align u_align (
    .raw_word    (raw_word),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .load_word   (load_word),
    .lane_en     (lane_en),
    .store_word  (store_word)
  );

`ifdef MEM_MISALIGN_FAULT_EN
  assign access_err = (size_reg == MEM_SZ_RSV)
                   || (size_reg == MEM_SZ_H && addr_reg[0])
                   || (size_reg == MEM_SZ_W && addr_reg[1:0] != 2'b00);
`else
  assign access_err = (size_reg == MEM_SZ_RSV);
`endif

  // The RESP cycle ends on the response edge, where stores land and loads are sampled.
  assign commit = (state_reg == RESP) && we_reg && !access_err;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) mem_reg[lane_idx[i]] <= store_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      unsigned_reg  <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= MEM_SZ_B;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            unsigned_reg <= req_unsigned;
            addr_reg     <= req_addr[IDX_W-1:0];
            size_reg     <= mem_size_e'(req_size);
            wdata_reg    <= req_wdata;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            cnt_reg   <= '0;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= access_err;
          rsp_rdata_reg <= (access_err || we_reg) ? 32'h0 : load_word;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_riscv_unified_mem.sv
// Scoreboard bench for riscv_unified_mem: one instance with LATENCY=1 and one with LATENCY=4.
module tb_riscv_unified_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic        busy [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] rdata;
    bit          err;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    riscv_unified_mem #(
      .ADDR_W(32), .DEPTH_BYTES(256), .LATENCY(gi == 0 ? 1 : 4), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
      .req_addr(req_addr[gi]), .req_size(req_size[gi]), .req_unsigned(req_unsigned[gi]),
      .req_wdata(req_wdata[gi]), .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]),
      .rsp_err(rsp_err[gi]), .busy(busy[gi])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Reference: little-endian bytes, index modulo 256, extension by plain arithmetic.
  function automatic void model_access(input int k, input bit we, input logic [31:0] addr,
                                       input logic [1:0] size, input bit uns,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output bit err);
    int     n;
    int     base;
    longint v;
    n     = 1 << size;
    base  = int'(addr % 256);
    v     = 0;
    err   = (size == 2'd3);
`ifdef MEM_MISALIGN_FAULT_EN
    if (size == 2'd1 && addr % 2 != 0) err = 1'b1;
    if (size == 2'd2 && addr % 4 != 0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[k][(base + i) % 256] = 8'(wdata >> (8 * i));
    end else begin
      for (int i = 0; i < n; i++) v += longint'(model_mem[k][(base + i) % 256]) << (8 * i);
      if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rdata = 32'(v);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every response pops the oldest expectation, including its arrival edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid[k] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp k=%0d cyc=%0d rdata=%h err=%0d", k, cyc, rsp_rdata[k], rsp_err[k]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.k != k || e.cyc != cyc || rsp_rdata[k] !== e.rdata || rsp_err[k] !== e.err) begin
            errors++;
            $display("FAIL rsp_%s k=%0d cyc=%0d rdata=%h err=%0d | exp k=%0d cyc=%0d rdata=%h err=%0d",
                     e.name, k, cyc, rsp_rdata[k], rsp_err[k], e.k, e.cyc, e.rdata, e.err);
          end else begin
            $display("rsp k=%0d %s cyc=%0d rdata=%h err=%0d", k, e.name, cyc, rsp_rdata[k], rsp_err[k]);
          end
        end
      end
    end
  end

  task automatic issue(input int k, input bit we, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata, input bit spam, input string name);
    exp_t e;
    int   waited;
    waited = 0;
    while (req_ready[k] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout k=%0d got=%b exp=1", name, k, req_ready[k]);
      return;
    end
    req_valid[k]    = 1'b1;
    req_we[k]       = we;
    req_addr[k]     = addr;
    req_size[k]     = size;
    req_unsigned[k] = uns;
    req_wdata[k]    = wdata;
    model_access(k, we, addr, size, uns, wdata, e.rdata, e.err);
    e.k    = k;
    e.cyc  = cyc + 1 + lat(k);
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    if (spam) begin
      // Requests while busy must be ignored; the model is left untouched.
      for (int c = 0; c < lat(k); c++) begin
        req_valid[k]    = 1'b1;
        req_we[k]       = 1'($urandom);
        req_addr[k]     = $urandom;
        req_size[k]     = 2'($urandom);
        req_unsigned[k] = 1'($urandom);
        req_wdata[k]    = $urandom;
        chk("busy_ready_busy", {30'h0, req_ready[k], busy[k]}, 32'h1);
        @(negedge clk);
      end
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_rsp_valid"}, 32'(rsp_valid[k]), 32'h0);
      chk({name, "_rsp_rdata"}, rsp_rdata[k], 32'h0);
      chk({name, "_rsp_err"},   32'(rsp_err[k]), 32'h0);
      chk({name, "_busy"},      32'(busy[k]), 32'h0);
      chk({name, "_req_ready"}, 32'(req_ready[k]), 32'h1);
    end
  endtask

  task automatic reset_inflight(input int k);
    issue(k, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, "pre_rst_lw");
    for (int i = 0; i < 50 && req_ready[k] !== 1'b1; i++) @(negedge clk);
    // Store accepted, then reset lands before its commit edge.
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_addr[k]  = 32'h80;
    req_size[k]  = 2'd2;
    req_wdata[k] = 32'h11223344;
    @(negedge clk);
    req_valid[k] = 1'b0;
    reset        = 1'b0;
    #1;
    check_reset_outputs("inflight_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(k, 1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 1'b0, "rst_kept_word");
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_size[k] = '0; req_unsigned[k] = 1'b0; req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a += 4) issue(k, 1'b1, 32'(a), 2'd2, 1'b0, $urandom, 1'b0, "fill");

      issue(k, 1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, "sw_40");
      issue(k, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b1, "lw_40");
      issue(k, 1'b0, 32'h40, 2'd0, 1'b0, 32'h0, 1'b0, "lb_40");
      issue(k, 1'b0, 32'h40, 2'd0, 1'b1, 32'h0, 1'b0, "lbu_40");
      issue(k, 1'b0, 32'h42, 2'd1, 1'b0, 32'h0, 1'b0, "lh_42");
      issue(k, 1'b0, 32'h42, 2'd1, 1'b1, 32'h0, 1'b0, "lhu_42");
      issue(k, 1'b1, 32'h41, 2'd0, 1'b0, 32'h12345678, 1'b0, "sb_41");
      issue(k, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, "lw_40_after_sb");
      issue(k, 1'b1, 32'h000000FE, 2'd2, 1'b0, 32'hAABBCCDD, 1'b0, "sw_fe_wrap");
      issue(k, 1'b0, 32'h000000FE, 2'd0, 1'b1, 32'h0, 1'b0, "lbu_fe");
      issue(k, 1'b0, 32'h000000FF, 2'd0, 1'b1, 32'h0, 1'b0, "lbu_ff");
      issue(k, 1'b0, 32'hABCD0100, 2'd0, 1'b1, 32'h0, 1'b0, "lbu_00_hiaddr");
      issue(k, 1'b0, 32'h00000301, 2'd0, 1'b1, 32'h0, 1'b0, "lbu_01_hiaddr");
      issue(k, 1'b0, 32'h000000FE, 2'd2, 1'b0, 32'h0, 1'b0, "lw_fe_wrap");
      issue(k, 1'b0, 32'h40, 2'd3, 1'b0, 32'h0, 1'b1, "ld_rsv");
      issue(k, 1'b1, 32'h40, 2'd3, 1'b0, 32'h55555555, 1'b0, "st_rsv");
      issue(k, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, "lw_40_after_rsv");

      for (int i = 0; i < 120; i++) begin
        issue(k, 1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
              $urandom, 1'($urandom_range(0, 3) == 0), "rand");
      end

      reset_inflight(k);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
